// File: rtl/mux4x1_rr_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg: shared constants and types for the 4-channel round-robin stream
// multiplexer.
//   NUM_CH : number of input lanes
//   SEL_W  : width of the channel tag / pointer
//   sel_t  : channel index type (00 = lane 0 ... 11 = lane 3)
//   onehot4: one-hot decode of a channel index
// ---------------------------------------------------------------------------
package mux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] sel_t;

  function automatic logic [NUM_CH-1:0] onehot4(input sel_t idx);
    logic [NUM_CH-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux4x1_rr_if.sv
// ---------------------------------------------------------------------------
// mux4x1_rr_if: bundles the four input lanes and the single output lane.
//   master modport : environment side (drives in_*, out_ready)
//   slave  modport : multiplexer side (drives in_ready, out_*)
// in_last exists only when MUX4X1_LOCK_EN is defined.
//
// Handshake: a beat moves on a lane in any cycle where valid and ready are
// both 1 at the rising edge of clk. A source holds valid and its data stable
// until the beat is taken; ready may change freely and carries no meaning
// while valid is 0.
// ---------------------------------------------------------------------------
interface mux4x1_rr_if #(
  parameter int WIDTH = 8
);
  import mux_pkg::*;

  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
`ifdef MUX4X1_LOCK_EN
  logic [NUM_CH-1:0]       in_last;
`endif
  logic [WIDTH-1:0]        out_data;
  sel_t                    out_sel;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data, in_valid,
`ifdef MUX4X1_LOCK_EN
    output in_last,
`endif
    input  in_ready,
    input  out_data, out_sel, out_valid,
    output out_ready
  );

  modport slave (
    input  in_data, in_valid,
`ifdef MUX4X1_LOCK_EN
    input  in_last,
`endif
    output in_ready,
    output out_data, out_sel, out_valid,
    input  out_ready
  );

endinterface

// File: rtl/mux4x1_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter4: combinational 4-way round-robin arbiter.
//   req     : per-lane request
//   ptr     : highest-priority lane this cycle; search runs ptr, ptr+1, ...
//   enable  : when 0, gnt is forced to 0 (gnt_idx/any still report the winner)
//   gnt     : one-hot grant
//   gnt_idx : index of the winning lane
//   any     : at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter4
  import mux_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  sel_t              ptr,
  input  logic              enable,
  output logic [NUM_CH-1:0] gnt,
  output sel_t              gnt_idx,
  output logic              any
);

  sel_t idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    // Walk from the farthest offset down to offset 0 so the lane closest to
    // ptr overwrites earlier hits and wins.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = ptr + sel_t'(k);
      if (req[idx]) begin
        gnt_idx = idx;
        any     = 1'b1;
      end
    end
    if (enable && any) gnt = onehot4(gnt_idx);
  end

endmodule

// File: rtl/mux4x1_rr.sv
// ---------------------------------------------------------------------------
// mux4x1_rr: merges four valid/ready lanes onto one registered output lane,
// tagging each beat with its source channel (out_sel). Round-robin grant.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : mux4x1_rr_if.slave (in_data/in_valid/in_ready[/in_last],
//           out_data/out_sel/out_valid/out_ready)
// Optional feature MUX4X1_LOCK_EN: once a lane is accepted with in_last = 0,
// the grant stays on that lane until its in_last = 1 beat, so bursts never
// interleave on out_sel.
// ---------------------------------------------------------------------------
module mux4x1_rr
  import mux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          reset,
  mux4x1_rr_if.slave   bus
);

  logic [WIDTH-1:0]  data_q;
  sel_t              sel_q;
  logic              valid_q;
  sel_t              ptr_q;

  logic              load;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] gnt;
  sel_t              gnt_idx;
  logic              any;
  logic              accept;

  // Output register can take a beat when empty or being drained this edge.
  assign load = !valid_q || bus.out_ready;

`ifdef MUX4X1_LOCK_EN
  logic lock_q;
  // While locked, sel_q still names the lane that owns the burst.
  assign req = lock_q ? (bus.in_valid & onehot4(sel_q)) : bus.in_valid;
`else
  assign req = bus.in_valid;
`endif

  rr_arbiter4 u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .enable  (load && !reset),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign accept      = any && load && !reset;
  assign bus.in_ready = gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
`ifdef MUX4X1_LOCK_EN
      lock_q  <= 1'b0;
`endif
    end else if (accept) begin
      data_q  <= bus.in_data[int'(gnt_idx)*WIDTH +: WIDTH];
      sel_q   <= gnt_idx;
      valid_q <= 1'b1;
`ifdef MUX4X1_LOCK_EN
      lock_q  <= !bus.in_last[gnt_idx];
      if (bus.in_last[gnt_idx]) ptr_q <= gnt_idx + sel_t'(1);
`else
      ptr_q   <= gnt_idx + sel_t'(1);
`endif
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_mux4x1_rr.sv
// ---------------------------------------------------------------------------
// tb_mux4x1_rr: directed self-checking bench for mux4x1_rr.
// Inputs change on the falling edge; outputs are checked on the falling edge
// (registered outputs) or 1 time unit after an input change (in_ready).
// ---------------------------------------------------------------------------
module tb_mux4x1_rr;
  import mux_pkg::*;

  localparam int WIDTH = 8;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  mux4x1_rr_if #(.WIDTH(WIDTH)) bus ();

  mux4x1_rr #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // one clock: rising edge, then settle to the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_lanes(input logic [3:0] valid);
    bus.in_valid = valid;
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [1:0] s, input logic [7:0] d);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    check({tag, ".sel"},   32'(bus.out_sel),   32'(s));
    check({tag, ".data"},  32'(bus.out_data),  32'(d));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset         = 1'b1;
    bus.in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
`ifdef MUX4X1_LOCK_EN
    bus.in_last   = 4'b1111;
`endif

    // Reset held 2 cycles with every lane valid
    tick();
    tick();
    check_out("reset", 1'b0, 2'd0, 8'h00);
    check("reset.in_ready", 32'(bus.in_ready), 32'h0);

    // Full contention: 0,1,2,3,0 with no bubbles
    reset = 1'b0;
    #1;
    check("rr0.in_ready", 32'(bus.in_ready), 32'b0001);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out($sformatf("rr%0d", i), 1'b1, 2'(i % 4), 8'(8'h10 + (i % 4)));
      check($sformatf("rr%0d.next_ready", i), 32'(bus.in_ready), 32'(4'b0001 << ((i + 1) % 4)));
    end
    // ptr now 1

    // Drain with nothing valid: out_valid drops, data/sel held
    set_lanes(4'b0000);
    check("idle.in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    check_out("drain", 1'b0, 2'd0, 8'h10);

    // Single lane 2 sends 0xA5
    bus.in_data[2*WIDTH +: WIDTH] = 8'hA5;
    set_lanes(4'b0100);
    check("single.in_ready", 32'(bus.in_ready), 32'b0100);
    tick();
    check_out("single", 1'b1, 2'd2, 8'hA5);
    set_lanes(4'b0000);
    check("single.ready_once", 32'(bus.in_ready), 32'h0);
    // ptr now 3

    // Backpressure for 5 cycles with lanes 3 and 0 waiting
    bus.in_data[2*WIDTH +: WIDTH] = 8'h12;
    bus.out_ready = 1'b0;
    set_lanes(4'b1001);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d.in_ready", i), 32'(bus.in_ready), 32'h0);
      tick();
      check_out($sformatf("bp%0d", i), 1'b1, 2'd2, 8'hA5);
    end

    // Release: load on the same edge; wrap order 3,0,3,0
    bus.out_ready = 1'b1;
    #1;
    check("wrap.first_ready", 32'(bus.in_ready), 32'b1000);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out($sformatf("wrap%0d", i), 1'b1, (i % 2 == 0) ? 2'd3 : 2'd0,
                (i % 2 == 0) ? 8'h13 : 8'h10);
    end

    // Reset mid-transfer: held beat discarded, no in_ready that cycle
    bus.out_ready = 1'b0;
    tick();
    check("midrst.held", 32'(bus.out_valid), 32'h1);
    reset = 1'b1;
    #1;
    check("midrst.in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    check_out("midrst", 1'b0, 2'd0, 8'h00);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    set_lanes(4'b0000);
    tick();

`ifdef MUX4X1_LOCK_EN
    // Lane 1 3-beat burst while lane 0 also valid: 01,01,01 then 00
    bus.in_data = {8'h13, 8'h12, 8'hB1, 8'h10};
    bus.in_last = 4'b0001;
    set_lanes(4'b0010);
    tick();
    check_out("lock.b0", 1'b1, 2'd1, 8'hB1);
    set_lanes(4'b0011);
    check("lock.b1.in_ready", 32'(bus.in_ready), 32'b0010);
    tick();
    check_out("lock.b1", 1'b1, 2'd1, 8'hB1);
    bus.in_last = 4'b0011;
    #1;
    check("lock.b2.in_ready", 32'(bus.in_ready), 32'b0010);
    tick();
    check_out("lock.b2", 1'b1, 2'd1, 8'hB1);
    set_lanes(4'b0001);
    check("lock.after.in_ready", 32'(bus.in_ready), 32'b0001);
    tick();
    check_out("lock.after", 1'b1, 2'd0, 8'h10);
    set_lanes(4'b0000);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
